// File: rtl/pc_pkg.sv
// Shared encodings and default vectors for the program-counter unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pc_pkg;

  // Next-PC source select; codes 4-7 fall back to sequential.
  localparam logic [2:0] PC_SEL_SEQ    = 3'd0;
  localparam logic [2:0] PC_SEL_BRANCH = 3'd1;
  localparam logic [2:0] PC_SEL_JUMP   = 3'd2;
  localparam logic [2:0] PC_SEL_REG    = 3'd3;

  // Last fault cause reported to software.
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_EXT      = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_BOUNDS   = 2'd3;

  // Run state vs exception-handler state.
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } pc_state_t;

  // Default vectors.
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR   = 32'h8000_0180;
  localparam logic [31:0] PC_BOUND_LO     = 32'h0000_0000;
  localparam logic [31:0] PC_BOUND_HI     = 32'h0000_FFFC;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC candidate generation plus misaligned-target and (PC_BOUNDS_EN) range checks.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results are always valid for the current inputs.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INC   = 4
`ifdef PC_BOUNDS_EN
  ,
  parameter logic [WIDTH-1:0] BOUND_LO = PC_BOUND_LO,
  parameter logic [WIDTH-1:0] BOUND_HI = PC_BOUND_HI
`endif
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             pc_write,
  input  logic [2:0]       pc_sel,
  input  logic [WIDTH-1:0] branch_off,
  input  logic [25:0]      jtarget,
  input  logic [WIDTH-1:0] reg_target,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] cand,
  output logic             misalign,
  output logic             bounds_err
);

  assign pc_plus4 = pc + WIDTH'(INC);

  // Select the candidate; reserved select codes behave as sequential.
  always_comb begin
    cand = pc_plus4;
    case (pc_sel)
      PC_SEL_BRANCH: cand = pc_plus4 + (branch_off << 2);
      PC_SEL_JUMP:   cand = {pc_plus4[WIDTH-1:28], jtarget, 2'b00};
      PC_SEL_REG:    cand = reg_target;
      default:       cand = pc_plus4;
    endcase
  end

  // Only a register target can be misaligned; the other sources are word-built.
  assign misalign = pc_write && (pc_sel == PC_SEL_REG) && (reg_target[1:0] != 2'b00);

`ifdef PC_BOUNDS_EN
  // Misalignment is reported in preference to an out-of-range target.
  assign bounds_err = pc_write && !misalign && ((cand < BOUND_LO) || (cand > BOUND_HI));
`else
  assign bounds_err = 1'b0;
`endif

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, exception vectoring, EPC capture and eret.
// Latency: every update appears on pc_out one cycle after the enabling edge; pc_plus4 is combinational.
// Backpressure: none; pc_write=0 holds the PC. Optional range check under macro PC_BOUNDS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = PC_EXC_VECTOR,
  parameter int               INC          = 4
`ifdef PC_BOUNDS_EN
  ,
  parameter logic [WIDTH-1:0] BOUND_LO     = PC_BOUND_LO,
  parameter logic [WIDTH-1:0] BOUND_HI     = PC_BOUND_HI
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic [2:0]       pc_sel,
  input  logic [WIDTH-1:0] branch_off,
  input  logic [25:0]      jtarget,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             in_exc,
  output logic [1:0]       cause,
  output logic             fault
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic             fault_q, fault_d;
  pc_state_t        state_q, state_d;

  logic [WIDTH-1:0] cand;
  logic             misalign;
  logic             bounds_err;
  logic             take_exc;

  pc_next_calc #(
    .WIDTH    (WIDTH),
    .INC      (INC)
`ifdef PC_BOUNDS_EN
    ,
    .BOUND_LO (BOUND_LO),
    .BOUND_HI (BOUND_HI)
`endif
  ) u_calc (
    .pc         (pc_q),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .branch_off (branch_off),
    .jtarget    (jtarget),
    .reg_target (reg_target),
    .pc_plus4   (pc_plus4),
    .cand       (cand),
    .misalign   (misalign),
    .bounds_err (bounds_err)
  );

  assign take_exc = exc_req || misalign || bounds_err;

  // Next-state and next-register values: exception > eret > pc_write > hold.
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    state_d = state_q;
    fault_d = 1'b0;
    if (take_exc) begin
      pc_d    = EXC_VECTOR;
      fault_d = 1'b1;
      state_d = ST_EXC;
      // A nested fault must not lose the original return address.
      if (state_q == ST_RUN) epc_d = pc_q;
      // Faults caused by the current instruction are reported ahead of the external request.
      if (misalign)        cause_d = CAUSE_MISALIGN;
      else if (bounds_err) cause_d = CAUSE_BOUNDS;
      else                 cause_d = CAUSE_EXT;
    end else if (eret) begin
      // eret outside the handler is a no-op and also suppresses pc_write.
      if (state_q == ST_EXC) begin
        pc_d    = epc_q;
        state_d = ST_RUN;
        cause_d = CAUSE_NONE;
      end
    end else if (pc_write) begin
      pc_d = cand;
    end
  end

  // State and register update with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      fault_q <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      fault_q <= fault_d;
      state_q <= state_d;
    end
  end

  assign pc_out = pc_q;
  assign epc    = epc_q;
  assign cause  = cause_q;
  assign fault  = fault_q;
  assign in_exc = (state_q == ST_EXC);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed steps push expected state, a monitor compares each cycle.
// Latency: expected values apply one rising edge after the inputs are driven.
// Backpressure: n/a.
module tb_pc_unit;

  localparam logic [31:0] EXCV = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic [2:0]  pc_sel = 3'd0;
  logic [31:0] branch_off = '0;
  logic [25:0] jtarget = '0;
  logic [31:0] reg_target = '0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] pc_out, pc_plus4, epc;
  logic        in_exc, fault;
  logic [1:0]  cause;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        in_exc;
    logic [1:0]  cause;
    logic        fault;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  pc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .branch_off (branch_off),
    .jtarget    (jtarget),
    .reg_target (reg_target),
    .exc_req    (exc_req),
    .eret       (eret),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .epc        (epc),
    .in_exc     (in_exc),
    .cause      (cause),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, req);
    end
  endfunction

  // Monitor: the DUT presents new state after every rising edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "pc_out",   pc_out,          e.pc);
        chk(nm, "pc_plus4", pc_plus4,        e.pc + 32'd4);
        chk(nm, "epc",      epc,             e.epc);
        chk(nm, "in_exc",   {31'd0, in_exc}, {31'd0, e.in_exc});
        chk(nm, "cause",    {30'd0, cause},  {30'd0, e.cause});
        chk(nm, "fault",    {31'd0, fault},  {31'd0, e.fault});
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic w, input logic [2:0] sel,
                      input logic [31:0] boff, input logic [25:0] jt, input logic [31:0] rt,
                      input logic ex, input logic er,
                      input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic e_exc, input logic [1:0] e_cause, input logic e_fault);
    exp_t e;
    @(negedge clk);
    rst = r; pc_write = w; pc_sel = sel; branch_off = boff; jtarget = jt;
    reg_target = rt; exc_req = ex; eret = er;
    e.pc = e_pc; e.epc = e_epc; e.in_exc = e_exc; e.cause = e_cause; e.fault = e_fault;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    logic [31:0] epc_exp;
    int          guard;
    //    name        rst w  sel   boff          jt        rt            ex er   pc            epc       exc cause flt
    step("reset",     1, 0, 3'd0, 32'd0,        26'd0,    32'd0,        0, 0,   32'h0,        32'h0,    0, 2'd0, 0);
    step("seq1",      0, 1, 3'd0, 32'd0,        26'd0,    32'd0,        0, 0,   32'h4,        32'h0,    0, 2'd0, 0);
    step("seq2",      0, 1, 3'd0, 32'd0,        26'd0,    32'd0,        0, 0,   32'h8,        32'h0,    0, 2'd0, 0);
    step("seq3",      0, 1, 3'd0, 32'd0,        26'd0,    32'd0,        0, 0,   32'hC,        32'h0,    0, 2'd0, 0);
    step("rsvd_seq",  0, 1, 3'd6, 32'd0,        26'd0,    32'd0,        0, 0,   32'h10,       32'h0,    0, 2'd0, 0);
    step("reg40",     0, 1, 3'd3, 32'd0,        26'd0,    32'h40,       0, 0,   32'h40,       32'h0,    0, 2'd0, 0);
    step("branch",    0, 1, 3'd1, 32'hFFFF_FFFE, 26'd0,   32'd0,        0, 0,   32'h3C,       32'h0,    0, 2'd0, 0);
`ifndef PC_BOUNDS_EN
    step("reg_hi",    0, 1, 3'd3, 32'd0,        26'd0,    32'h1000_0040, 0, 0,  32'h1000_0040, 32'h0,   0, 2'd0, 0);
    step("jump",      0, 1, 3'd2, 32'd0,        26'h10,   32'd0,        0, 0,   32'h1000_0040, 32'h0,   0, 2'd0, 0);
`endif
    step("reg20",     0, 1, 3'd3, 32'd0,        26'd0,    32'h20,       0, 0,   32'h20,       32'h0,    0, 2'd0, 0);
    step("misalign",  0, 1, 3'd3, 32'd0,        26'd0,    32'h102,      0, 0,   EXCV,         32'h20,   1, 2'd2, 1);
    step("exc_hold",  0, 0, 3'd0, 32'd0,        26'd0,    32'd0,        0, 0,   EXCV,         32'h20,   1, 2'd2, 0);
    step("nested",    0, 0, 3'd0, 32'd0,        26'd0,    32'd0,        1, 0,   EXCV,         32'h20,   1, 2'd1, 1);
    step("eret",      0, 0, 3'd0, 32'd0,        26'd0,    32'd0,        0, 1,   32'h20,       32'h20,   0, 2'd0, 0);
    for (int i = 0; i < 5; i++)
      step("hold",    0, 0, 3'd0, 32'd0,        26'd0,    32'd0,        0, 0,   32'h20,       32'h20,   0, 2'd0, 0);
    step("eret_run",  0, 1, 3'd0, 32'd0,        26'd0,    32'd0,        0, 1,   32'h20,       32'h20,   0, 2'd0, 0);
    step("ext_exc",   0, 1, 3'd0, 32'd0,        26'd0,    32'd0,        1, 0,   EXCV,         32'h20,   1, 2'd1, 1);
    step("rst_exc",   1, 0, 3'd0, 32'd0,        26'd0,    32'd0,        1, 0,   32'h0,        32'h0,    0, 2'd0, 0);
`ifdef PC_BOUNDS_EN
    step("jump_oob",  0, 1, 3'd2, 32'd0,        26'h4000, 32'd0,        0, 0,   EXCV,         32'h0,    1, 2'd3, 1);
    epc_exp = 32'h0;
`else
    step("jump_oob",  0, 1, 3'd2, 32'd0,        26'h4000, 32'd0,        0, 0,   32'h0001_0000, 32'h0,   0, 2'd0, 0);
    epc_exp = 32'h0001_0000;
`endif
    step("exc_eret",  0, 0, 3'd0, 32'd0,        26'd0,    32'd0,        1, 1,   EXCV,         epc_exp,  1, 2'd1, 1);
    step("eret2",     0, 0, 3'd0, 32'd0,        26'd0,    32'd0,        0, 1,   epc_exp,      epc_exp,  0, 2'd0, 0);
    step("idle",      0, 0, 3'd0, 32'd0,        26'd0,    32'd0,        0, 0,   epc_exp,      epc_exp,  0, 2'd0, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    #4;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the multi-cycle MIPS core. It replaces the plain PC register.
- Holds the PC and computes the next PC internally: sequential, branch, jump, register (jr) or exception vector.
- Captures the exception return address in EPC and detects misaligned register targets.
- Sits between the control FSM (write enable, select) and the instruction-fetch memory address.

Parameters:
- WIDTH, 32, PC/data width; must be at least 32.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h8000_0180, PC value loaded on any exception.
- INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_write  in  1  update enable from the control FSM; PC holds when 0.
- pc_sel  in  3  next-PC source: 0 SEQ, 1 BRANCH, 2 JUMP, 3 REG; 4-7 reserved, treated as SEQ.
- branch_off  in  WIDTH  sign-extended immediate, in words.
- jtarget  in  26  J-type target field.
- reg_target  in  WIDTH  rs value for jr/jalr.
- exc_req  in  1  external exception request.
- eret  in  1  return from exception.
- pc_out  out  WIDTH  current PC.
- pc_plus4  out  WIDTH  pc_out+INC, combinational.
- epc  out  WIDTH  saved exception PC.
- in_exc  out  1  1 while in the EXC state.
- cause  out  2  last fault cause: 0 none, 1 external, 2 misaligned, 3 out of bounds.
- fault  out  1  one-cycle pulse when any exception is taken.

Behaviour:
- Reset (synchronous): pc_out=RESET_VECTOR, epc=0, state=RUN, in_exc=0, cause=0, fault=0. rst has priority over every other input in the same cycle.
- Next-PC candidate:
  - SEQ = pc_out+INC.
  - BRANCH = pc_plus4 + (branch_off<<2).
  - JUMP = {pc_plus4[WIDTH-1:28], jtarget, 2'b00}.
  - REG = reg_target.
  - All arithmetic is modulo 2^WIDTH; wrap-around is silent.
- Misaligned: pc_write=1 with pc_sel=REG and reg_target[1:0]!=0. This is treated as an internal exception with cause=2. The PC is never loaded with a misaligned value.
- Priority each cycle: rst > exception (exc_req or misaligned) > eret > pc_write > hold.
- Exception taken:
  - pc_out<=EXC_VECTOR; fault=1 for one cycle; cause updated; state<=EXC.
  - epc<=pc_out, but only if the state was RUN.
  - In the EXC state, epc is sticky: a nested exception re-vectors the PC and updates cause but does not overwrite epc.
- eret: honoured only in the EXC state. pc_out<=epc, state<=RUN, cause<=0. An eret in RUN is ignored and the PC holds.
- In the EXC state, pc_write/pc_sel work normally so the handler can execute.
- State machine has two states:
  - RUN→EXC on an exception.
  - EXC→RUN on eret.
  - EXC→EXC on a nested exception.
- Latency: all updates are visible on pc_out the cycle after the enabling edge. pc_plus4 follows pc_out combinationally.
- Simultaneous exc_req and eret: the exception wins; the state stays or becomes EXC.

Optional Feature:
- Macro PC_BOUNDS_EN.
- When defined: add parameters BOUND_LO (default 0) and BOUND_HI (default 32'h0000_FFFC).
  - Any pc_write candidate (not the exception vector, not eret) outside [BOUND_LO, BOUND_HI] raises an exception with cause=3. The PC is not loaded with that value.
  - Misaligned takes precedence over bounds.
- When undefined: no bounds check; cause value 3 is never produced.

Decomposition:
- Shared package pc_pkg holds:
  - pc_sel encodings: PC_SEL_SEQ, PC_SEL_BRANCH, PC_SEL_JUMP, PC_SEL_REG.
  - cause encodings: CAUSE_NONE, CAUSE_EXT, CAUSE_MISALIGN, CAUSE_BOUNDS.
  - state encoding for RUN/EXC.
  - Default vector constants.
- One sub-module, pc_next_calc: purely combinational candidate and misalign/bounds evaluation.
- pc_unit keeps the registers and the FSM.

Test Plan:
- Reset, then pc_write=1 with SEQ for 3 cycles → pc_out 0, 4, 8, 12; pc_plus4=16.
- At pc=0x40, BRANCH with branch_off=-2 → pc_out=0x3C. At pc=0x1000_0040, JUMP with jtarget=0x10 → pc_out=0x1000_0040.
- At pc=0x20, REG with reg_target=0x102 → fault pulse, cause=2, pc_out=EXC_VECTOR, epc=0x20, in_exc=1. A nested exc_req then leaves epc=0x20. eret → pc_out=0x20, in_exc=0.
- pc_write=0 for 5 cycles → pc_out held. eret while in RUN → no change.
- Assert rst mid-exception together with exc_req → next cycle pc_out=RESET_VECTOR, in_exc=0, epc=0, fault=0.
- With PC_BOUNDS_EN defined, JUMP to 0x0001_0000 → cause=3, pc_out=EXC_VECTOR. Without the macro, same stimulus → pc_out=0x0001_0000.
